cdc_pulse_arbiter: RTL and testbench
====================================

# cdc_pulse_arbiter

Source-domain scheduler that shares one `clk_sync_high_to_low` pulse-synchronizer channel among `NUM_REQ` requesters. It latches single-cycle requests, picks one by round-robin, and emits one pulse plus a stable requester tag. It then holds off a guard interval so the slower destination domain captures every pulse and tag. It sits entirely in the fast (source) clock domain, directly upstream of the synchronizer.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `TAG_W`, `$clog2(NUM_REQ)`: width of the requester tag.
- `GUARD_CYCLES`, 8: minimum idle `clk` cycles after each pulse, ≥1. The default covers 3 cycles of an ~83 MHz destination from a 200 MHz source.

- `clk` in 1: source-domain clock; sole clock of the block.
- `rst` in 1: reset, synchronous and active-low.
- `en_in` in 1: when low, no new pulse starts; requests still latch.
- `req_in` in `NUM_REQ`: per-requester single-cycle request strobes.
- `pend_out` out `NUM_REQ`: registered pending-request bits.
- `pulse_out` out 1: single-cycle pulse into the synchronizer input.
- `tag_out` out `TAG_W`: index of the last granted requester, held stable until the next pulse.
- `busy_out` out 1: high during the pulse cycle and all guard cycles.
- `merged_out` out `NUM_REQ`: one-cycle strobe when a request coalesces into an already-pending one.

## Operation
- Reset (`rst` low at an edge) sets all outputs and state to 0: `pend_out`, `pulse_out`, `tag_out`, `busy_out`, `merged_out`, and the guard counter. It also sets the FSM to IDLE and the round-robin pointer so requester 0 has highest priority.
- Reset has the same effect from any state. A pulse or guard in progress is abandoned and pending requests are discarded.
- Pending latch:
  - `req_in[i]` high at an edge sets `pend[i]`.
  - If `pend[i]` was already 1 and is not being granted that cycle, `merged_out[i]` pulses for one cycle.
- FSM states: IDLE and GUARD.
  - IDLE → GUARD when `en_in`=1 and `pend`≠0. At that edge the block does the following:
    - `pulse_out`←1 for one cycle.
    - `tag_out`←winner.
    - `pend[winner]` is cleared.
    - The pointer moves to winner.
    - The counter loads `GUARD_CYCLES`.
  - GUARD: the counter decrements each cycle.
  - When the counter reaches 0, the block applies the same launch condition as IDLE:
    - If the condition holds, it fires directly and stays in GUARD with the counter reloaded.
    - Otherwise it goes to IDLE.
- Round-robin: the search starts at (last winner + 1) mod `NUM_REQ` and takes the first set pending bit; after reset the search starts at 0.
- Grant and request on the same requester in the same cycle: clear-then-set. `pend[i]` stays 1, `merged_out[i]` stays 0, and a second pulse follows after the guard.
- `en_in` low: the FSM holds in IDLE, or finishes its guard and then holds. `pend` keeps accumulating and merging.
- `tag_out` never changes except on the edge that raises `pulse_out`.

## Timing
- Request latency: `req_in[i]` high in cycle t gives `pend_out[i]`=1 in cycle t+1. If the block is idle and enabled, `pulse_out`=1 with `tag_out`=i in cycle t+2 (2-cycle latency).
- `pend_out[i]` falls in the same cycle that `pulse_out` rises for i.
- Pulse spacing: if a pulse occurs in cycle p, the next pulse comes no earlier than p+`GUARD_CYCLES`+1. With continuous demand, pulses occur exactly every `GUARD_CYCLES`+1 cycles.
- `busy_out`=1 in cycles p..p+`GUARD_CYCLES` and is 0 in cycle p+`GUARD_CYCLES`+1 unless a new pulse launches there.
- `pulse_out` is never high two consecutive cycles. `merged_out` bits are one-cycle strobes.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `NUM_REQ`=4 and `GUARD_CYCLES`=8.

- **Single request:** `req_in`=4'b0100 in cycle 10.
  - `pend_out[2]`=1 in cycle 11.
  - `pulse_out`=1 and `tag_out`=2 in cycle 12.
  - `busy_out`=1 in cycles 12–20 and 0 in cycle 21.
  - `tag_out` stays 2 afterward.
- **Simultaneous burst:** `req_in`=4'b1111 in cycle 10 → pulses in cycles 12, 21, 30 and 39 with tags 0, 1, 2, 3.
- **Fairness:** requesters 1 and 3 re-request every cycle → tags alternate 1, 3, 1, 3 on pulses spaced 9 cycles apart. Requester 1 is never granted twice in a row.
- **Merge:**
  - `en_in`=0 while `req_in[0]` pulses in cycles 10 and 14 → `merged_out[0]`=1 in cycle 15 only.
  - `en_in`=1 from cycle 20 → exactly one pulse with tag 0, in cycle 21.
- **Grant/re-request collision:** `req_in[2]` is high in the same cycle as the grant edge for requester 2. `pend_out[2]` stays 1, `merged_out` stays 0, and a second tag-2 pulse occurs exactly 9 cycles later.
- **Reset mid-guard:** `rst`=0 at the 4th guard cycle with `pend`=4'b1010.
  - The next cycle shows all outputs 0.
  - Releasing `rst` with no new requests produces no pulse.
  - A subsequent `req_in`=4'b1111 is granted first to requester 0.

Source files
------------

// File: rtl/cdc_pulse_arbiter.sv
// Source-domain scheduler for a shared pulse synchronizer channel.
// Latches single-cycle requests and grants them round-robin. Each grant emits
// one pulse with a stable requester tag. A guard interval follows each pulse
// so the slower destination domain can capture the pulse and the tag.
module cdc_pulse_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TAG_W        = $clog2(NUM_REQ),
  parameter int GUARD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_in,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] pend_out,
  output logic               pulse_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               busy_out,
  output logic [NUM_REQ-1:0] merged_out
);

  localparam int CNT_W = $clog2(GUARD_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, GUARD = 1'b1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   guard_cnt;
  // Index where the next round-robin search begins (last winner + 1).
  logic [TAG_W-1:0]   rr_start;
  logic               launch;
  logic [TAG_W-1:0]   winner;
  logic [NUM_REQ-1:0] grant;

  // (base + off) mod NUM_REQ, valid for base < NUM_REQ and off <= NUM_REQ.
  function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] base,
                                                input int off);
    logic [TAG_W:0] s;
    s = {1'b0, base} + (TAG_W+1)'(off);
    if (s >= (TAG_W+1)'(NUM_REQ)) s = s - (TAG_W+1)'(NUM_REQ);
    return s[TAG_W-1:0];
  endfunction

  // First set pending bit searching upward from start, wrapping around.
  function automatic logic [TAG_W-1:0] rr_pick(input logic [NUM_REQ-1:0] p,
                                               input logic [TAG_W-1:0]   start);
    logic [2*NUM_REQ-1:0] rot;
    logic [TAG_W-1:0]     w;
    logic                 found;
    rot   = {p, p} >> start;
    w     = start;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        w     = wrap_add(start, i);
      end
    end
    return w;
  endfunction

  // Launch decision and one-hot grant for the current pending set.
  always_comb begin
    winner = rr_pick(pend_out, rr_start);
    launch = en_in && (pend_out != '0) && ((state == IDLE) || (guard_cnt == '0));
    grant  = '0;
    if (launch) grant[winner] = 1'b1;
  end

  // Pending latch, merge strobes, pulse/tag launch and guard-interval FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      guard_cnt  <= '0;
      rr_start   <= '0;
      pend_out   <= '0;
      pulse_out  <= 1'b0;
      tag_out    <= '0;
      busy_out   <= 1'b0;
      merged_out <= '0;
    end else begin
      // Clear-then-set: a request arriving on the grant edge stays pending.
      pend_out   <= (pend_out & ~grant) | req_in;
      merged_out <= req_in & pend_out & ~grant;
      pulse_out  <= launch;
      if (launch) begin
        tag_out  <= winner;
        rr_start <= wrap_add(winner, 1);
      end
      case (state)
        IDLE: begin
          if (launch) begin
            state     <= GUARD;
            guard_cnt <= CNT_W'(GUARD_CYCLES);
            busy_out  <= 1'b1;
          end else begin
            busy_out  <= 1'b0;
          end
        end
        GUARD: begin
          if (guard_cnt != '0) begin
            guard_cnt <= guard_cnt - CNT_W'(1);
            busy_out  <= 1'b1;
          end else if (launch) begin
            // Back-to-back demand: relaunch without passing through IDLE.
            guard_cnt <= CNT_W'(GUARD_CYCLES);
            busy_out  <= 1'b1;
          end else begin
            state     <= IDLE;
            busy_out  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_pulse_arbiter.sv
// Testbench for cdc_pulse_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// cycle-distance reference model.
module tb_cdc_pulse_arbiter;

  localparam int N = 4;
  localparam int G = 8;
  localparam int TW = $clog2(N);

  logic          clk;
  logic          rst;
  logic          en_in;
  logic [N-1:0]  req_in;
  logic [N-1:0]  pend_out;
  logic          pulse_out;
  logic [TW-1:0] tag_out;
  logic          busy_out;
  logic [N-1:0]  merged_out;

  int checks = 0;
  int errors = 0;
  int n = 0;

  cdc_pulse_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .req_in(req_in),
    .pend_out(pend_out), .pulse_out(pulse_out), .tag_out(tag_out),
    .busy_out(busy_out), .merged_out(merged_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  // Reference model: pending set, cycle of the last pulse, search start.
  logic [N-1:0]  m_pend = '0;
  int            m_last = -1000;
  int            m_start = 0;
  logic          e_pulse = 1'b0;
  logic [TW-1:0] e_tag = '0;
  logic          e_busy = 1'b0;
  logic [N-1:0]  e_merged = '0;
  logic [N-1:0]  m_grant;
  logic          m_launch;
  int            m_win;
  bit            synced = 1'b0;

  // Compare the current cycle, then predict the next one from this cycle's inputs.
  always @(negedge clk) begin
    if (synced) begin
      check("pend_out", 32'(pend_out), 32'(m_pend));
      check("pulse_out", 32'(pulse_out), 32'(e_pulse));
      check("tag_out", 32'(tag_out), 32'(e_tag));
      check("busy_out", 32'(busy_out), 32'(e_busy));
      check("merged_out", 32'(merged_out), 32'(e_merged));
    end
    if (!rst) begin
      m_pend = '0; e_pulse = 1'b0; e_tag = '0; e_busy = 1'b0; e_merged = '0;
      m_last = -1000; m_start = 0; synced = 1'b1;
    end else begin
      // A pulse may start in cycle n+1 only if at least G idle cycles followed the last one.
      m_launch = en_in && (m_pend != '0) && ((n + 1) - m_last >= G + 1);
      m_grant = '0;
      m_win = -1;
      if (m_launch) begin
        for (int k = 0; k < N; k++)
          if (m_win < 0 && m_pend[(m_start + k) % N]) m_win = (m_start + k) % N;
        m_grant[m_win] = 1'b1;
      end
      e_merged = req_in & m_pend & ~m_grant;
      m_pend   = (m_pend & ~m_grant) | req_in;
      e_pulse  = m_launch;
      if (m_launch) begin
        e_tag   = TW'(m_win);
        m_last  = n + 1;
        m_start = (m_win + 1) % N;
      end
      e_busy = ((n + 1) - m_last) <= G;
    end
    n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_in = '0; en_in = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  int qt[$];
  int qo[$];
  int cnt;

  initial begin
    rst = 1'b0; en_in = 1'b1; req_in = '0;
    tick(); tick(); tick();
    // Reset state
    check("rst_pend", 32'(pend_out), 32'h0);
    check("rst_pulse", 32'(pulse_out), 32'h0);
    check("rst_tag", 32'(tag_out), 32'h0);
    check("rst_busy", 32'(busy_out), 32'h0);
    check("rst_merged", 32'(merged_out), 32'h0);
    rst = 1'b1;
    repeat (3) tick();

    // Single request on requester 2
    do_reset();
    req_in = 4'b0100; tick(); req_in = '0;
    check("single_pend", 32'(pend_out), 32'h4);
    check("single_nopulse", 32'(pulse_out), 32'h0);
    tick();
    check("single_pulse", 32'(pulse_out), 32'h1);
    check("single_tag", 32'(tag_out), 32'h2);
    check("single_pend_clr", 32'(pend_out), 32'h0);
    check("single_busy0", 32'(busy_out), 32'h1);
    for (int k = 1; k <= G; k++) begin
      tick();
      check("single_busy_guard", 32'(busy_out), 32'h1);
      check("single_pulse_guard", 32'(pulse_out), 32'h0);
    end
    tick();
    check("single_busy_end", 32'(busy_out), 32'h0);
    check("single_tag_hold", 32'(tag_out), 32'h2);

    // Simultaneous burst
    do_reset();
    req_in = 4'b1111; tick(); req_in = '0;
    qt.delete(); qo.delete();
    for (int k = 1; k <= 40; k++) begin
      if (pulse_out) begin qt.push_back(int'(tag_out)); qo.push_back(k); end
      tick();
    end
    check("burst_count", 32'(qt.size()), 32'd4);
    if (qt.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("burst_tag", 32'(qt[i]), 32'(i));
        check("burst_time", 32'(qo[i]), 32'(2 + 9 * i));
      end
    end

    // Fairness between requesters 1 and 3
    do_reset();
    qt.delete(); qo.delete();
    req_in = 4'b1010;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (pulse_out) begin qt.push_back(int'(tag_out)); qo.push_back(k); end
    end
    req_in = '0;
    check("fair_count", 32'(qt.size() >= 4), 32'h1);
    if (qt.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("fair_tag", 32'(qt[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
      for (int i = 0; i < 3; i++) check("fair_spacing", 32'(qo[i+1] - qo[i]), 32'd9);
    end

    // Merge while disabled
    do_reset();
    en_in = 1'b0;
    req_in = 4'b0001; tick(); req_in = '0;
    check("merge_pend", 32'(pend_out), 32'h1);
    check("merge_first", 32'(merged_out), 32'h0);
    tick(); tick(); tick();
    req_in = 4'b0001; tick(); req_in = '0;
    check("merge_strobe", 32'(merged_out), 32'h1);
    check("merge_nopulse", 32'(pulse_out), 32'h0);
    en_in = 1'b1; tick();
    check("merge_strobe_end", 32'(merged_out), 32'h0);
    check("merge_pulse", 32'(pulse_out), 32'h1);
    check("merge_tag", 32'(tag_out), 32'h0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (pulse_out) cnt++; end
    check("merge_single_pulse", 32'(cnt), 32'h0);

    // Grant/re-request collision on requester 2
    do_reset();
    req_in = 4'b0100; tick(); tick(); req_in = '0;
    check("coll_pulse", 32'(pulse_out), 32'h1);
    check("coll_tag", 32'(tag_out), 32'h2);
    check("coll_pend", 32'(pend_out), 32'h4);
    check("coll_merged", 32'(merged_out), 32'h0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k < 9) check("coll_gap", 32'(pulse_out), 32'h0);
      else begin
        check("coll_second", 32'(pulse_out), 32'h1);
        check("coll_second_tag", 32'(tag_out), 32'h2);
      end
    end

    // Reset in the middle of a guard interval
    do_reset();
    req_in = 4'b0001; tick(); req_in = '0; tick();
    check("rmg_pulse", 32'(pulse_out), 32'h1);
    req_in = 4'b1010; tick(); req_in = '0;
    check("rmg_pend", 32'(pend_out), 32'ha);
    tick(); tick(); tick();
    rst = 1'b0; tick(); rst = 1'b1;
    check("rmg_pend0", 32'(pend_out), 32'h0);
    check("rmg_busy0", 32'(busy_out), 32'h0);
    check("rmg_tag0", 32'(tag_out), 32'h0);
    check("rmg_pulse0", 32'(pulse_out), 32'h0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (pulse_out) cnt++; end
    check("rmg_no_pulse", 32'(cnt), 32'h0);
    req_in = 4'b1111; tick(); req_in = '0; tick();
    check("rmg_first_pulse", 32'(pulse_out), 32'h1);
    check("rmg_first_tag", 32'(tag_out), 32'h0);

    // Randomized traffic with occasional disables and resets
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      req_in = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      en_in  = ($urandom_range(0, 7) != 0);
      rst    = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst = 1'b1; en_in = 1'b1; req_in = '0;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
